// File: rtl/imem_fetch_port.sv
// Writable instruction memory with a valid/ready fetch port, one-entry response buffer,
// a post-reset clear sequence and misaligned / out-of-range fault flags.
module imem_fetch_port #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 64,
    parameter int unsigned       AW        = $clog2(DEPTH),
    parameter logic [31:0]       BASE_ADDR = 32'h0,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(32'h00000013)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [31:0]       rsp_pc,
    output logic [1:0]        rsp_fault,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
    logic [31:0]       rsp_pc_q, rsp_pc_d;
    logic [1:0]        rsp_fault_q, rsp_fault_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [31:0]       off_c;
    logic [AW-1:0]     idx_c;
    logic              mis_c;
    logic              oor_c;
    logic              accept_c;
    logic              mem_we_c;
    logic [AW-1:0]     mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
    assign accept_c  = req_valid && req_ready;

    // Address decode; the offset is unsigned so addresses below BASE_ADDR never wrap into range.
    always_comb begin
        off_c = req_pc - BASE_ADDR;
        idx_c = off_c[AW+1:2];
        mis_c = (req_pc[1:0] != 2'b00);
        oor_c = (req_pc < BASE_ADDR) || ((off_c >> 2) >= 32'(DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_instr_d = rsp_instr_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_fault_d = rsp_fault_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = clr_cnt_q;
        mem_wdata_c = FILL_WORD;
        case (state_q)
            ST_INIT: begin
                mem_we_c  = 1'b1;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (prog_we) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = prog_addr;
                    mem_wdata_c = prog_data;
                end
                // The read samples the array before this edge's write lands (read-before-write).
                if (accept_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_pc_d    = req_pc;
                    rsp_fault_d = {oor_c, mis_c};
                    rsp_instr_d = (mis_c || oor_c) ? FILL_WORD : mem[idx_c];
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
            rsp_pc_q    <= '0;
            rsp_fault_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Storage array has no reset; the clear sequence defines its contents.
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign init_done = init_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_instr = rsp_instr_q;
    assign rsp_pc    = rsp_pc_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: directed scenarios with literal expectations plus random traffic,
// all cross-checked every cycle against a behavioural model.
module tb_imem_fetch_port;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;
    localparam longint unsigned BASE = 0;
    localparam logic [31:0] FILL  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_done;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_pc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic [1:0]  rsp_fault;
    logic        prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0] prog_data = '0;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    imem_fetch_port #(
        .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .FILL_WORD(FILL)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_pc(rsp_pc), .rsp_fault(rsp_fault),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: init countdown, a one-deep response slot and a plain word array.
    logic [31:0] m_mem [DEPTH];
    int          m_cnt = 0;
    bit          m_run = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc = '0;
    logic [1:0]  m_fault = '0;

    always @(posedge clk) begin
        longint unsigned pcv;
        bit mis, oor, rdy;
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_valid = 1'b0;
            m_instr = '0; m_pc = '0; m_fault = '0;
        end else if (!m_run) begin
            m_mem[m_cnt] = FILL;
            m_cnt++;
            if (m_cnt == DEPTH) m_run = 1'b1;
        end else begin
            rdy = !m_valid || rsp_ready;
            if (req_valid && rdy) begin
                pcv = longint'(req_pc);
                mis = (pcv % 4) != 0;
                oor = (pcv < BASE) || (((pcv - BASE) / 4) >= DEPTH);
                m_instr = (mis || oor) ? FILL : m_mem[int'((pcv - BASE) / 4)];
                m_pc    = req_pc;
                m_fault = {oor, mis};
                m_valid = 1'b1;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            if (prog_we) m_mem[prog_addr] = prog_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("init_done", 64'(init_done), 64'(m_run));
            check("req_ready", 64'(req_ready), 64'(m_run && (!m_valid || rsp_ready)));
            check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
            if (m_valid) begin
                check("rsp_instr", 64'(rsp_instr), 64'(m_instr));
                check("rsp_pc", 64'(rsp_pc), 64'(m_pc));
                check("rsp_fault", 64'(rsp_fault), 64'(m_fault));
            end
        end
    end

    task automatic wait_init(input string name);
        int  cnt;
        bit  rdy_seen;
        cnt = 0;
        rdy_seen = 1'b0;
        while (!init_done && cnt < 200) begin
            if (req_ready) rdy_seen = 1'b1;
            tick();
            cnt++;
        end
        check({name, "_cycles"}, 64'(cnt), 64'(DEPTH));
        check({name, "_ready_in_init"}, 64'(rdy_seen), 64'(0));
    endtask

    initial begin
        logic [31:0] pcs [3];
        logic [1:0]  fl  [3];
        pcs[0] = 32'h6;   fl[0] = 2'b01;
        pcs[1] = 32'h100; fl[1] = 2'b10;
        pcs[2] = 32'h102; fl[2] = 2'b11;

        // Reset and clear sequence
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        tick();
        rst = 1'b0;
        wait_init("init1");
        req_valid = 1'b1; req_pc = 32'h8; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("fetch8_valid", 64'(rsp_valid), 64'(1));
        check("fetch8_instr", 64'(rsp_instr), 64'(32'h13));
        check("fetch8_fault", 64'(rsp_fault), 64'(0));
        tick();

        // Program then stream
        for (int i = 0; i < 4; i++) begin
            prog_we = 1'b1; prog_addr = AW'(i); prog_data = 32'(32'h11 * (i + 1));
            tick();
        end
        prog_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_pc = 32'(4 * i);
            tick();
            check("stream_valid", 64'(rsp_valid), 64'(1));
            check("stream_instr", 64'(rsp_instr), 64'(32'h11 * (i + 1)));
            check("stream_pc", 64'(rsp_pc), 64'(4 * i));
        end
        req_valid = 1'b0;
        tick();
        check("stream_drain", 64'(rsp_valid), 64'(0));

        // Backpressure
        req_valid = 1'b1; req_pc = 32'h4; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; req_pc = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 64'(req_ready), 64'(0));
            check("bp_instr", 64'(rsp_instr), 64'(32'h22));
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'(1));
        tick();
        check("bp_next_instr", 64'(rsp_instr), 64'(32'h33));
        check("bp_next_pc", 64'(rsp_pc), 64'(32'h8));
        req_valid = 1'b0;
        tick();

        // Faults
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_pc = pcs[i];
            tick();
            check("fault_flags", 64'(rsp_fault), 64'(fl[i]));
            check("fault_instr", 64'(rsp_instr), 64'(32'h13));
        end
        req_valid = 1'b0;
        tick();

        // Same-edge write and fetch
        prog_we = 1'b1; prog_addr = AW'(2); prog_data = 32'hAB;
        req_valid = 1'b1; req_pc = 32'h8;
        tick();
        prog_we = 1'b0;
        check("rbw_old", 64'(rsp_instr), 64'(32'h33));
        tick();
        check("rbw_new", 64'(rsp_instr), 64'(32'hAB));
        req_valid = 1'b0;
        tick();

        // Random traffic, including occasional resets
        for (int n = 0; n < 2500; n++) begin
            rst       = ($urandom_range(0, 599) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       req_pc = $urandom();
                1:       req_pc = 32'($urandom_range(0, 300));
                default: req_pc = 32'($urandom_range(0, 70) * 4);
            endcase
            rsp_ready = ($urandom_range(0, 3) != 0);
            prog_we   = ($urandom_range(0, 2) == 0);
            prog_addr = AW'($urandom_range(0, DEPTH - 1));
            prog_data = $urandom();
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
        tick();

        // Reset mid-clear, with program writes attempted during the clear
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prog_we = 1'b1; prog_addr = AW'(5); prog_data = 32'hDEAD;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init("init2");
        prog_we = 1'b0;
        req_valid = 1'b1; req_pc = 32'h14;
        tick();
        req_valid = 1'b0;
        check("init2_word5", 64'(rsp_instr), 64'(32'h13));
        check("init2_fault", 64'(rsp_fault), 64'(0));
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
